instr_fetch_queue: RTL

- Parametrised successor to the single-cycle instruction memory.
- Word-addressed instruction RAM with synchronous read, a program-load write port, an internal fetch PC, and a prefetch queue with valid/ready handshake toward decode.
- Each queue head is presented with MIPS field split (op/rs/rt/rd/Sa/Immediate).
- Sits between the PC/branch logic (redirect) and the decode/control stage.

---
 rtl/instr_fetch_queue.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Word-addressed instruction RAM with a synchronous read port, a program-load
// write port, an internal fetch PC and a prefetch queue that presents one
// instruction per cycle to decode through a valid/ready handshake.  The
// queue head is also shown split into MIPS fields.
//
// Parameters
//   MEM_WORDS : instruction RAM depth in 32-bit words (power of 2)
//   QDEPTH    : prefetch queue entries (>= 2)
//   RESET_PC  : byte address fetched first after reset
//
// Ports
//   CLK, Reset          : clock (rising edge), synchronous active-high reset
//   RW                  : fetch enable (0 = issue no new reads)
//   load_we/addr/data   : program-load write port (byte address, [1:0] ignored)
//   redirect/_pc        : flush queue, drop in-flight read, restart fetch
//   inst_valid/ready    : handshake toward decode
//   inst_pc/instruction : head byte address and word
//   op/rs/rt/rd/Sa/Immediate : MIPS field split of the head word
//   inst_err            : head was fetched beyond MEM_WORDS (word forced to 0)
//
// Optional feature (macro IM_PERF_CNT_EN)
//   fetch_cnt : number of pops since reset
//   stall_cnt : cycles with inst_valid=1 and inst_ready=0 since reset
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int          MEM_WORDS = 256,
   parameter int          QDEPTH    = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        RW,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] instruction,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  Sa,
   output logic [15:0] Immediate,
   output logic        inst_err
`ifdef IM_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = QW + 2;

   // Instruction RAM and its registered read data
   logic [31:0]   r_mem [MEM_WORDS];
   logic [31:0]   r_rd_data;

   // Fetch state
   logic [31:0]   r_fetch_pc;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic          r_inflight_err;

   // Prefetch queue storage
   logic [31:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_word [QDEPTH];
   logic          r_q_err  [QDEPTH];
   logic [QW-1:0] r_wr_ptr;
   logic [QW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW-1:0] w_occ;
   logic          w_load_ok;
   logic          w_fetch_oor;
   logic [AW-1:0] w_load_idx;
   logic [AW-1:0] w_fetch_idx;
   logic          w_unused;

   assign inst_valid  = (r_count != '0);
   assign w_pop       = inst_valid & inst_ready;
   // Slots committed after this edge: queued + in flight - leaving now.
   // A pop implies r_count >= 1, so this never underflows.
   assign w_occ       = r_count + CW'(r_inflight) - CW'(w_pop);
   assign w_issue     = RW & ~load_we & ~redirect & (w_occ < CW'(QDEPTH));
   // A redirect discards the word currently returning from the RAM
   assign w_push      = r_inflight & ~redirect;

   assign w_load_ok   = (load_addr[31:AW+2] == '0);
   assign w_fetch_oor = |r_fetch_pc[31:AW+2];
   assign w_load_idx  = load_addr[AW+1:2];
   assign w_fetch_idx = r_fetch_pc[AW+1:2];
   assign w_unused    = ^load_addr[1:0];

   function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
      return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // RAM: write and read never collide because no read issues during a load.
   // Out-of-range fetch indices alias; the err flag zeroes the word at push.
   always_ff @(posedge CLK) begin
      if (load_we && w_load_ok) begin
         r_mem[w_load_idx] <= load_data;
      end
      if (w_issue) begin
         r_rd_data <= r_mem[w_fetch_idx];
      end
   end

   // Fetch PC, in-flight tracking and queue pointers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_fetch_pc     <= RESET_PC;
         r_inflight     <= 1'b0;
         r_inflight_pc  <= '0;
         r_inflight_err <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc & ~32'h3;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc  <= r_fetch_pc;
            r_inflight_err <= w_fetch_oor;
            r_fetch_pc     <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Queue entries; cleared on reset so the head outputs read as zero
   generate
      for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
         always_ff @(posedge CLK) begin
            if (Reset) begin
               r_q_pc[gi]   <= '0;
               r_q_word[gi] <= '0;
               r_q_err[gi]  <= 1'b0;
            end else if (w_push && (r_wr_ptr == QW'(gi))) begin
               r_q_pc[gi]   <= r_inflight_pc;
               r_q_word[gi] <= r_inflight_err ? 32'h0 : r_rd_data;
               r_q_err[gi]  <= r_inflight_err;
            end
         end
      end
   endgenerate

   assign inst_pc     = r_q_pc[r_rd_ptr];
   assign instruction = r_q_word[r_rd_ptr];
   assign inst_err    = r_q_err[r_rd_ptr];
   assign op          = instruction[31:26];
   assign rs          = instruction[25:21];
   assign rt          = instruction[20:16];
   assign rd          = instruction[15:11];
   assign Sa          = instruction[10:6];
   assign Immediate   = instruction[15:0];

`ifdef IM_PERF_CNT_EN
   // Counters ignore redirect; only Reset clears them
   always_ff @(posedge CLK) begin
      if (Reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (w_pop) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (inst_valid && !inst_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
